// File: rtl/reg_bank_ctrl_if.sv
// Host command/response bus plus RAM request/read-data bus of the register bank controller.
// Latency: pure wiring, no storage.
// Backpressure: cmd_ready throttles the host, mem_req_ready throttles the controller's RAM requests.
interface reg_bank_ctrl_if;
   // host command channel
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [3:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   // host read response
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   // RAM request channel
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_write;
   logic [31:0] mem_req_addr;
   logic [15:0] mem_req_wdata;
   // RAM read data return
   logic        mem_rd_valid;
   logic [15:0] mem_rd_data;

   // environment side: host bridge and RAM model
   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output mem_req_ready, mem_rd_valid, mem_rd_data,
      input  cmd_ready, rsp_valid, rsp_rdata,
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
   );

   // controller side
   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  mem_req_ready, mem_rd_valid, mem_rd_data,
      output cmd_ready, rsp_valid, rsp_rdata,
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
   );
endinterface

// File: rtl/reg_bank_ctrl.sv
// Host register bank: config registers, status/interrupt views, 0x0E/0x0F RAM window with auto-increment.
// Latency: register read response 1 cycle after accept; RAM read response 1 cycle after mem_rd_valid.
// Backpressure: cmd_ready drops while a RAM transaction is open; mem_req_* held stable until mem_req_ready.
module reg_bank_ctrl #(
   parameter logic [15:0] VERSION        = 16'h0001,
   parameter logic [15:0] CONV_CFG1_INIT = 16'h0401
) (
   input  logic        clk,
   input  logic        rst_n,
   reg_bank_ctrl_if.slave bus,
   output logic [31:0] cfg_addr_o,
   output logic [15:0] cfg_conv1_o,
   output logic [15:0] cfg_conv2_o,
   output logic [15:0] cfg_conv3_o,
   output logic [15:0] cfg_conv4_o,
   input  logic        conv_done_i,
   input  logic        conv_running_i,
   input  logic [13:0] conv_count_i,
   input  logic        ev_mem_load_i,
   input  logic        ev_conv_i,
   input  logic        ev_dense_i,
   output logic        irq_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM_WR,
      S_MEM_RD_REQ,
      S_MEM_RD_WAIT
   } state_t;

   localparam logic [3:0] A_VERSION = 4'h0;
   localparam logic [3:0] A_ADDR_LO = 4'h1;
   localparam logic [3:0] A_ADDR_HI = 4'h2;
   localparam logic [3:0] A_CONV1   = 4'h3;
   localparam logic [3:0] A_CONV2   = 4'h4;
   localparam logic [3:0] A_CONV3   = 4'h5;
   localparam logic [3:0] A_CONV4   = 4'h6;
   localparam logic [3:0] A_STATUS  = 4'h7;
   localparam logic [3:0] A_INT     = 4'h8;
   localparam logic [3:0] A_MEM_WR  = 4'hE;
   localparam logic [3:0] A_MEM_RD  = 4'hF;

   state_t      state_q;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic [15:0] rsp_rdata_q;
   logic        mem_req_valid_q;
   logic        mem_req_write_q;
   logic [31:0] mem_req_addr_q;
   logic [15:0] mem_req_wdata_q;
   logic [31:0] addr_q;
   logic [15:0] conv1_q, conv2_q, conv3_q, conv4_q;
   // interrupt bit index: 2 = mem_load, 1 = conv, 0 = dense
   logic [2:0]  int_en_q;
   logic [2:0]  int_act_q;
   logic [2:0]  int_act_d;
   logic        irq_q;

   logic        acc_rd;
   logic        acc_wr;
   logic [2:0]  ev_vec;
   logic [15:0] int_view;
   logic [15:0] rd_mux;
   logic [31:0] addr_inc;

   assign acc_rd   = bus.cmd_valid & cmd_ready_q & ~bus.cmd_write;
   assign acc_wr   = bus.cmd_valid & cmd_ready_q &  bus.cmd_write;
   assign ev_vec   = {ev_mem_load_i, ev_conv_i, ev_dense_i};
   assign int_view = {int_en_q[2], int_act_q[2], int_en_q[1], int_act_q[1],
                      int_en_q[0], int_act_q[0], 10'b0};
   // wraps modulo 2^32, so a carry naturally reaches the upper half
   assign addr_inc = addr_q + 32'd1;

   // Active bits: a reading access of 0x08 clears them, but an event in that same cycle survives
   always_comb begin
      int_act_d = int_act_q | ev_vec;
      if (acc_rd && (bus.cmd_addr == A_INT)) begin
         int_act_d = ev_vec;
      end
   end

   // Register read view; 0x0E, 0x0F and unmapped addresses read as zero
   always_comb begin
      rd_mux = 16'h0000;
      case (bus.cmd_addr)
         A_VERSION: rd_mux = VERSION;
         A_ADDR_LO: rd_mux = addr_q[15:0];
         A_ADDR_HI: rd_mux = addr_q[31:16];
         A_CONV1:   rd_mux = conv1_q;
         A_CONV2:   rd_mux = conv2_q;
         A_CONV3:   rd_mux = conv3_q;
         A_CONV4:   rd_mux = conv4_q;
         A_STATUS:  rd_mux = {conv_done_i, conv_running_i, conv_count_i};
         A_INT:     rd_mux = int_view;
         default:   rd_mux = 16'h0000;
      endcase
   end

   // Command FSM: host handshake, responses, RAM window and the shared RAM address register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         cmd_ready_q     <= 1'b1;
         rsp_valid_q     <= 1'b0;
         rsp_rdata_q     <= 16'h0000;
         mem_req_valid_q <= 1'b0;
         mem_req_write_q <= 1'b0;
         mem_req_addr_q  <= 32'h0;
         mem_req_wdata_q <= 16'h0000;
         addr_q          <= 32'h0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (acc_rd) begin
                  if (bus.cmd_addr == A_MEM_RD) begin
                     state_q         <= S_MEM_RD_REQ;
                     cmd_ready_q     <= 1'b0;
                     mem_req_valid_q <= 1'b1;
                     mem_req_write_q <= 1'b0;
                     mem_req_addr_q  <= addr_q;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= rd_mux;
                  end
               end else if (acc_wr) begin
                  case (bus.cmd_addr)
                     A_ADDR_LO: addr_q[15:0]  <= bus.cmd_wdata;
                     A_ADDR_HI: addr_q[31:16] <= bus.cmd_wdata;
                     A_MEM_WR: begin
                        state_q         <= S_MEM_WR;
                        cmd_ready_q     <= 1'b0;
                        mem_req_valid_q <= 1'b1;
                        mem_req_write_q <= 1'b1;
                        mem_req_addr_q  <= addr_q;
                        mem_req_wdata_q <= bus.cmd_wdata;
                     end
                     default: ;
                  endcase
               end
            end
            S_MEM_WR: begin
               if (bus.mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  addr_q          <= addr_inc;
                  cmd_ready_q     <= 1'b1;
                  state_q         <= S_IDLE;
               end
            end
            S_MEM_RD_REQ: begin
               if (bus.mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= S_MEM_RD_WAIT;
               end
            end
            S_MEM_RD_WAIT: begin
               if (bus.mem_rd_valid) begin
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= bus.mem_rd_data;
                  addr_q      <= addr_inc;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q         <= S_IDLE;
               cmd_ready_q     <= 1'b1;
               mem_req_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Configuration and interrupt registers; irq follows enable/active state one cycle late
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv1_q   <= CONV_CFG1_INIT;
         conv2_q   <= 16'h0000;
         conv3_q   <= 16'h0000;
         conv4_q   <= 16'h0000;
         int_en_q  <= 3'b000;
         int_act_q <= 3'b000;
         irq_q     <= 1'b0;
      end else begin
         int_act_q <= int_act_d;
         irq_q     <= |(int_en_q & int_act_q);
         if (acc_wr) begin
            case (bus.cmd_addr)
               A_CONV1: conv1_q  <= bus.cmd_wdata;
               A_CONV2: conv2_q  <= bus.cmd_wdata;
               A_CONV3: conv3_q  <= bus.cmd_wdata;
               A_CONV4: conv4_q  <= bus.cmd_wdata;
               A_INT:   int_en_q <= {bus.cmd_wdata[15], bus.cmd_wdata[13], bus.cmd_wdata[11]};
               default: ;
            endcase
         end
      end
   end

   assign bus.cmd_ready     = cmd_ready_q;
   assign bus.rsp_valid     = rsp_valid_q;
   assign bus.rsp_rdata     = rsp_rdata_q;
   assign bus.mem_req_valid = mem_req_valid_q;
   assign bus.mem_req_write = mem_req_write_q;
   assign bus.mem_req_addr  = mem_req_addr_q;
   assign bus.mem_req_wdata = mem_req_wdata_q;
   assign cfg_addr_o        = addr_q;
   assign cfg_conv1_o       = conv1_q;
   assign cfg_conv2_o       = conv2_q;
   assign cfg_conv3_o       = conv3_q;
   assign cfg_conv4_o       = conv4_q;
   assign irq_o             = irq_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl: register map, interrupt view, RAM window and mid-transaction reset.
// Latency: checks sampled 1 ns after each rising edge.
// Backpressure: RAM ready/read-valid driven by hand in the stimulus sequence.
module tb_reg_bank_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] cfg_addr;
   logic [15:0] cfg_conv1, cfg_conv2, cfg_conv3, cfg_conv4;
   logic        conv_done, conv_running;
   logic [13:0] conv_count;
   logic        ev_mem_load, ev_conv, ev_dense;
   logic        irq;

   int checks = 0;
   int errors = 0;

   reg_bank_ctrl_if bus_if ();

   reg_bank_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus_if),
      .cfg_addr_o     (cfg_addr),
      .cfg_conv1_o    (cfg_conv1),
      .cfg_conv2_o    (cfg_conv2),
      .cfg_conv3_o    (cfg_conv3),
      .cfg_conv4_o    (cfg_conv4),
      .conv_done_i    (conv_done),
      .conv_running_i (conv_running),
      .conv_count_i   (conv_count),
      .ev_mem_load_i  (ev_mem_load),
      .ev_conv_i      (ev_conv),
      .ev_dense_i     (ev_dense),
      .irq_o          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // register read with optional event pulses in the accept cycle; response expected next cycle
   task automatic host_read(input logic [3:0] a, input logic [2:0] ev, input logic [15:0] exp,
                            input string tag);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b0;
      bus_if.cmd_addr  = a;
      {ev_mem_load, ev_conv, ev_dense} = ev;
      tick();
      bus_if.cmd_valid = 1'b0;
      {ev_mem_load, ev_conv, ev_dense} = 3'b000;
      chk({tag, "_vld"}, {31'b0, bus_if.rsp_valid}, 32'd1);
      chk(tag, {16'b0, bus_if.rsp_rdata}, {16'b0, exp});
      tick();
      chk({tag, "_pulse"}, {31'b0, bus_if.rsp_valid}, 32'd0);
   endtask

   task automatic host_write(input logic [3:0] a, input logic [15:0] d);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b1;
      bus_if.cmd_addr  = a;
      bus_if.cmd_wdata = d;
      tick();
      bus_if.cmd_valid = 1'b0;
   endtask

   task automatic issue_mem_read();
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b0;
      bus_if.cmd_addr  = 4'hF;
      tick();
      bus_if.cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n                = 1'b1;
      bus_if.cmd_valid     = 1'b0;
      bus_if.cmd_write     = 1'b0;
      bus_if.cmd_addr      = 4'h0;
      bus_if.cmd_wdata     = 16'h0000;
      bus_if.mem_req_ready = 1'b0;
      bus_if.mem_rd_valid  = 1'b0;
      bus_if.mem_rd_data   = 16'h0000;
      conv_done            = 1'b0;
      conv_running         = 1'b0;
      conv_count           = 14'h0;
      ev_mem_load          = 1'b0;
      ev_conv              = 1'b0;
      ev_dense             = 1'b0;

      // reset state
      #3 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_cmd_ready", {31'b0, bus_if.cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", {16'b0, bus_if.rsp_rdata}, 32'h0);
      chk("rst_mem_valid", {31'b0, bus_if.mem_req_valid}, 32'd0);
      chk("rst_irq", {31'b0, irq}, 32'd0);
      chk("rst_conv1", {16'b0, cfg_conv1}, 32'h0401);
      chk("rst_addr", cfg_addr, 32'h0);
      rst_n = 1'b1;
      tick();

      // reset values through the bus
      host_read(4'h0, 3'b000, 16'h0001, "rd_version");
      host_read(4'h3, 3'b000, 16'h0401, "rd_conv1_init");
      host_read(4'h8, 3'b000, 16'h0000, "rd_int_init");

      // config writes, read-only and unmapped behaviour
      host_write(4'h4, 16'hCAFE);
      chk("conv2_out", {16'b0, cfg_conv2}, 32'hCAFE);
      host_read(4'h4, 3'b000, 16'hCAFE, "rd_conv2");
      host_write(4'h6, 16'h1357);
      chk("conv4_out", {16'b0, cfg_conv4}, 32'h1357);
      host_write(4'h0, 16'hFFFF);
      host_read(4'h0, 3'b000, 16'h0001, "rd_version_ro");
      host_read(4'hA, 3'b000, 16'h0000, "rd_unmapped");
      host_read(4'hE, 3'b000, 16'h0000, "rd_0e");
      chk("rd_0e_no_mem", {31'b0, bus_if.mem_req_valid}, 32'd0);
      host_write(4'hF, 16'h5555);
      chk("wr_0f_no_mem", {31'b0, bus_if.mem_req_valid}, 32'd0);
      chk("wr_0f_ready", {31'b0, bus_if.cmd_ready}, 32'd1);

      // status view
      conv_done = 1'b1; conv_running = 1'b0; conv_count = 14'h0ABC;
      host_read(4'h7, 3'b000, 16'h8ABC, "rd_status_a");
      conv_done = 1'b0; conv_running = 1'b1; conv_count = 14'h3FFF;
      host_read(4'h7, 3'b000, 16'h7FFF, "rd_status_b");

      // interrupt register: enables only, clear-on-read, irq registered
      host_write(4'h8, 16'hFFFF);
      host_read(4'h8, 3'b000, 16'hA800, "rd_int_en");
      chk("irq_en_only", {31'b0, irq}, 32'd0);
      ev_conv = 1'b1;
      tick();
      ev_conv = 1'b0;
      tick();
      chk("irq_conv", {31'b0, irq}, 32'd1);
      host_read(4'h8, 3'b000, 16'hB800, "rd_int_conv");
      host_read(4'h8, 3'b000, 16'hA800, "rd_int_cleared");
      chk("irq_cleared", {31'b0, irq}, 32'd0);
      // event coinciding with a clearing read must survive
      host_read(4'h8, 3'b001, 16'hA800, "rd_int_race");
      host_read(4'h8, 3'b000, 16'hAC00, "rd_int_dense");
      host_write(4'h8, 16'h0000);

      // RAM write at top of address space with backpressure
      host_write(4'h1, 16'hFFFF);
      host_write(4'h2, 16'hFFFF);
      chk("addr_max", cfg_addr, 32'hFFFF_FFFF);
      host_write(4'hE, 16'h1234);
      chk("mw_ready0", {31'b0, bus_if.cmd_ready}, 32'd0);
      chk("mw_valid", {31'b0, bus_if.mem_req_valid}, 32'd1);
      chk("mw_write", {31'b0, bus_if.mem_req_write}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mw_hold_valid", {31'b0, bus_if.mem_req_valid}, 32'd1);
         chk("mw_hold_addr", bus_if.mem_req_addr, 32'hFFFF_FFFF);
         chk("mw_hold_wdata", {16'b0, bus_if.mem_req_wdata}, 32'h1234);
         chk("mw_hold_ready", {31'b0, bus_if.cmd_ready}, 32'd0);
      end
      bus_if.mem_req_ready = 1'b1;
      tick();
      bus_if.mem_req_ready = 1'b0;
      chk("mw_done_valid", {31'b0, bus_if.mem_req_valid}, 32'd0);
      chk("mw_done_ready", {31'b0, bus_if.cmd_ready}, 32'd1);
      chk("mw_wrap_addr", cfg_addr, 32'h0);
      host_read(4'h1, 3'b000, 16'h0000, "rd_addr_lo_wrap");
      host_read(4'h2, 3'b000, 16'h0000, "rd_addr_hi_wrap");

      // RAM read with delayed data return
      host_write(4'h1, 16'h0010);
      issue_mem_read();
      chk("mr_valid", {31'b0, bus_if.mem_req_valid}, 32'd1);
      chk("mr_write", {31'b0, bus_if.mem_req_write}, 32'd0);
      chk("mr_addr", bus_if.mem_req_addr, 32'h0000_0010);
      chk("mr_ready0", {31'b0, bus_if.cmd_ready}, 32'd0);
      bus_if.mem_req_ready = 1'b1;
      tick();
      bus_if.mem_req_ready = 1'b0;
      chk("mr_req_done", {31'b0, bus_if.mem_req_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mr_wait_rsp", {31'b0, bus_if.rsp_valid}, 32'd0);
      end
      bus_if.mem_rd_valid = 1'b1;
      bus_if.mem_rd_data  = 16'hBEEF;
      tick();
      bus_if.mem_rd_valid = 1'b0;
      chk("mr_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd1);
      chk("mr_rsp_data", {16'b0, bus_if.rsp_rdata}, 32'hBEEF);
      chk("mr_addr_inc", cfg_addr, 32'h0000_0011);
      chk("mr_ready1", {31'b0, bus_if.cmd_ready}, 32'd1);
      tick();
      chk("mr_rsp_pulse", {31'b0, bus_if.rsp_valid}, 32'd0);

      // reset while waiting for RAM data, then a late data beat
      host_write(4'h3, 16'h0203);
      chk("conv1_wr", {16'b0, cfg_conv1}, 32'h0203);
      bus_if.mem_req_ready = 1'b1;
      issue_mem_read();
      tick();
      bus_if.mem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rr_mem_valid", {31'b0, bus_if.mem_req_valid}, 32'd0);
      chk("rr_cmd_ready", {31'b0, bus_if.cmd_ready}, 32'd1);
      chk("rr_conv1", {16'b0, cfg_conv1}, 32'h0401);
      chk("rr_addr", cfg_addr, 32'h0);
      #2 rst_n = 1'b1;
      bus_if.mem_rd_valid = 1'b1;
      bus_if.mem_rd_data  = 16'hDEAD;
      tick();
      bus_if.mem_rd_valid = 1'b0;
      chk("late_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
      chk("late_cmd_ready", {31'b0, bus_if.cmd_ready}, 32'd1);
      chk("late_addr", cfg_addr, 32'h0);
      tick();
      chk("late_rsp_valid2", {31'b0, bus_if.rsp_valid}, 32'd0);
      host_read(4'h0, 3'b000, 16'h0001, "rd_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
